// File: rtl/pe_pkg.sv
// Shared types and constants for the round-robin PE scheduler.
// State encodings are plain 2-bit constants so checkers can bind to them directly.
package pe_pkg;

    localparam int PE_MAX_REQ = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One in-flight operation: valid flag plus owning requester id.
    typedef struct packed {
        logic       v;
        logic [2:0] id;
    } pe_tag_t;

endpackage

// File: rtl/pe_rr_sched_rr_pick.sv
// Rotate-priority picker: first set bit of valid_i at or after ptr_i, wrapping modulo NREQ.
// ptr_i must be below NREQ.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [2:0]      ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [2:0]      idx_o,
    output logic            any_o
);

    logic [NREQ-1:0] rot;
    logic [3:0]      sum;

    // Rotate so ptr_i lands at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        rot   = NREQ'({valid_i, valid_i} >> ptr_i);
        any_o = |rot;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) sum = {1'b0, ptr_i} + 4'(k);
        end
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        idx_o   = sum[2:0];
        grant_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/pe_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency PE among NREQ requesters.
// Optional feature macro: PE_RR_SCHED_PERF_EN adds saturating per-requester grant counters.
// Handshake: a requester transfer happens in a cycle where req_valid_i[r] & req_ready_o[r];
// the PE and the response sinks never stall, so pe_valid_o and rsp_valid_o are pure strobes.
module pe_rr_sched
    import pe_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int PE_LAT = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*DATA_W-1:0] req_a_i,
    input  logic [NREQ*DATA_W-1:0] req_b_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic                   pe_valid_o,
    output logic [DATA_W-1:0]      pe_a_o,
    output logic [DATA_W-1:0]      pe_b_o,
    input  logic [DATA_W-1:0]      pe_res_i,
    output logic [NREQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_data_o,
`ifdef PE_RR_SCHED_PERF_EN
    output logic [NREQ*16-1:0]     grant_cnt_o,
`endif
    output logic [1:0]             dbg_state_o
);

    logic [2:0]      ptr_q;
    logic [1:0]      state_q;
    logic            done_hold_q;
    pe_tag_t         tag_q [PE_LAT];
    pe_tag_t         tag_last;
    logic            grant_en;
    logic [NREQ-1:0] grant;
    logic [2:0]      gidx;
    logic            gany;
    logic            pipe_busy;

    // Grants only while running and not in the cycle a flush is raised; reset forces all outputs low.
    assign grant_en = rst_ni && (state_q == ST_RUN) && !flush_i;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i (req_valid_i & {NREQ{grant_en}}),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    assign req_ready_o  = grant;
    assign pe_valid_o   = gany;
    assign tag_last     = tag_q[PE_LAT-1];
    assign rsp_valid_o  = tag_last.v ? (NREQ'(1) << tag_last.id) : '0;
    assign rsp_data_o   = tag_last.v ? pe_res_i : '0;
    assign flush_done_o = (state_q == ST_DONE) && !done_hold_q;
    assign dbg_state_o  = state_q;

    // Operand mux for the granted requester; zero when nothing is granted.
    always_comb begin
        pe_a_o = '0;
        pe_b_o = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant[r]) begin
                pe_a_o = req_a_i[r*DATA_W +: DATA_W];
                pe_b_o = req_b_i[r*DATA_W +: DATA_W];
            end
        end
    end

    // Any valid tag means a result is still owed to some requester.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < PE_LAT; i++) pipe_busy = pipe_busy | tag_q[i].v;
    end

    // Round-robin pointer moves just past the last granted requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (gany) begin
            ptr_q <= (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;
        end
    end

    // Tag pipeline mirrors the PE latency so each result meets its owner's id.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PE_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= {gany, gidx};
            for (int i = 1; i < PE_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Flush FSM; done_hold_q keeps DONE silent while flush_i stays high after the pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            done_hold_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush_i) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    done_hold_q <= 1'b0;
                    if (!pipe_busy) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (!flush_i) begin
                        state_q     <= ST_RUN;
                        done_hold_q <= 1'b0;
                    end else begin
                        done_hold_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    done_hold_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PE_RR_SCHED_PERF_EN
    logic [15:0] cnt_q [NREQ];

    // Saturating per-requester grant counters, cleared when a drain completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREQ; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (flush_done_o) cnt_q[r] <= '0;
                else if (grant[r] && (cnt_q[r] != 16'hFFFF)) cnt_q[r] <= cnt_q[r] + 16'd1;
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        grant_cnt_o = '0;
        for (int r = 0; r < NREQ; r++) grant_cnt_o[r*16 +: 16] = cnt_q[r];
    end
`endif

endmodule

// File: tb/tb_pe_rr_sched.sv
// Self-checking bench for pe_rr_sched (NREQ=4, DATA_W=32, PE_LAT=3).
// Build with PE_RR_SCHED_PERF_EN defined to also exercise the grant counters.
module tb_pe_rr_sched;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int PE_LAT = 3;

  logic                   clk_i;
  logic                   rst_ni;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*DATA_W-1:0] req_a_i;
  logic [NREQ*DATA_W-1:0] req_b_i;
  logic [NREQ-1:0]        req_ready_o;
  logic                   flush_i;
  logic                   flush_done_o;
  logic                   pe_valid_o;
  logic [DATA_W-1:0]      pe_a_o;
  logic [DATA_W-1:0]      pe_b_o;
  logic [DATA_W-1:0]      pe_res_i;
  logic [NREQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]      rsp_data_o;
  logic [1:0]             dbg_state_o;
`ifdef PE_RR_SCHED_PERF_EN
  logic [NREQ*16-1:0]     grant_cnt_o;
`endif

  pe_rr_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .PE_LAT(PE_LAT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_ready_o  (req_ready_o),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .pe_valid_o   (pe_valid_o),
    .pe_a_o       (pe_a_o),
    .pe_b_o       (pe_b_o),
    .pe_res_i     (pe_res_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
`ifdef PE_RR_SCHED_PERF_EN
    .grant_cnt_o  (grant_cnt_o),
`endif
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- external PE: fixed-latency arithmetic ----------------
  function automatic logic [DATA_W-1:0] pe_fn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return a * b + 32'd1;
  endfunction

  logic [DATA_W-1:0] pe_pipe [PE_LAT];
  initial for (int i = 0; i < PE_LAT; i++) pe_pipe[i] = '0;
  always @(posedge clk_i) begin
    pe_pipe[0] <= pe_valid_o ? pe_fn(pe_a_o, pe_b_o) : 32'hBAD0_BAD0;
    for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign pe_res_i = pe_pipe[PE_LAT-1];

  // ---------------- stimulus storage ----------------
  logic [DATA_W-1:0] opa [NREQ];
  logic [DATA_W-1:0] opb [NREQ];
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      req_a_i[r*DATA_W +: DATA_W] = opa[r];
      req_b_i[r*DATA_W +: DATA_W] = opb[r];
    end
  end

  // ---------------- scoreboard and reference model ----------------
  typedef struct packed {
    logic [31:0]       due;
    logic [7:0]        id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   m_ptr;
  bit   m_en;
  int   m_cnt [NREQ];
  int   done_at;
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic randomize_ops();
    for (int r = 0; r < NREQ; r++) begin
      opa[r] = $urandom;
      opb[r] = $urandom;
    end
  endtask

  // One clock cycle: check every output against the model at the negedge, then advance.
  task automatic step();
    int                g;
    logic [NREQ-1:0]   eg;
    logic [DATA_W-1:0] ea, eb, erd;
    logic [NREQ-1:0]   erv;
    rsp_t              e;
    @(negedge clk_i);
    g = -1;
    if (m_en) begin
      for (int k = 0; k < NREQ; k++) begin
        int r;
        r = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid_i[r]) g = r;
      end
    end
    eg = '0; ea = '0; eb = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ea = opa[g];
      eb = opb[g];
    end
    chk("req_ready", req_ready_o, eg);
    chk("pe_valid", pe_valid_o, g >= 0);
    chk("pe_a", pe_a_o, ea);
    chk("pe_b", pe_b_o, eb);
    erv = '0; erd = '0;
    if (exp_q.size() > 0 && int'(exp_q[0].due) == cyc) begin
      e = exp_q.pop_front();
      erv[int'(e.id)] = 1'b1;
      erd = e.data;
    end
    chk("rsp_valid", rsp_valid_o, erv);
    chk("rsp_data", rsp_data_o, erd);
    chk("flush_done", flush_done_o, done_at == cyc);
    if (done_at == cyc) for (int r = 0; r < NREQ; r++) m_cnt[r] = 0;
    if (g >= 0) begin
      exp_q.push_back('{due: 32'(cyc + PE_LAT), id: 8'(g), data: pe_fn(ea, eb)});
      m_ptr = (g + 1) % NREQ;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, req_ready_o, 0);
    chk({tag, "_pe_valid"}, pe_valid_o, 0);
    chk({tag, "_pe_a"}, pe_a_o, 0);
    chk({tag, "_pe_b"}, pe_b_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_data"}, rsp_data_o, 0);
    chk({tag, "_flush_done"}, flush_done_o, 0);
    chk({tag, "_state"}, dbg_state_o, 0);
  endtask

`ifdef PE_RR_SCHED_PERF_EN
  task automatic chk_cnt(input string tag);
    for (int r = 0; r < NREQ; r++)
      chk($sformatf("%s_cnt%0d", tag, r), grant_cnt_o[r*16 +: 16], m_cnt[r]);
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int last;
    rst_ni = 1'b1; flush_i = 1'b0; req_valid_i = '0;
    for (int r = 0; r < NREQ; r++) begin opa[r] = '0; opb[r] = '0; m_cnt[r] = 0; end
    m_ptr = 0; m_en = 1'b1; done_at = -1;

    // Reset state, with requests already waiting.
    req_valid_i = 4'hF;
    #1 rst_ni = 1'b0;
    #1 chk_zero_outputs("reset");
    req_valid_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Single requester 1: A=5, B=7.
    req_valid_i = 4'b0010; opa[1] = 32'd5; opb[1] = 32'd7;
    step();
    req_valid_i = '0;
    repeat (4) step();

    // Move pointer to 0, then all four valid for 8 cycles.
    req_valid_i = 4'b1000; randomize_ops();
    step();
    req_valid_i = 4'hF;
    for (int i = 0; i < 8; i++) begin randomize_ops(); step(); end
    req_valid_i = '0;
    repeat (4) step();

    // Wrap-around: pointer to 3, requesters 3 and 0 valid.
    req_valid_i = 4'b0100; randomize_ops();
    step();
    req_valid_i = 4'b1001;
    step();
    randomize_ops();
    step();
    req_valid_i = 4'hF;
    step();
    req_valid_i = '0;
    repeat (4) step();

    // Flush with two operations in flight; flush held past the pulse.
    req_valid_i = 4'hF; randomize_ops();
    step();
    step();
    last = cyc - 1;
    flush_i = 1'b1; m_en = 1'b0; done_at = last + 5;
    repeat (7) step();
    flush_i = 1'b0;
    step();
    m_en = 1'b1; done_at = -1;
`ifdef PE_RR_SCHED_PERF_EN
    chk_cnt("after_flush");
`endif
    for (int i = 0; i < 4; i++) begin randomize_ops(); step(); end
    req_valid_i = '0;
    repeat (4) step();

    // Flush on an empty pipeline: pulse two cycles after assertion.
    req_valid_i = 4'hF;
    flush_i = 1'b1; m_en = 1'b0; done_at = cyc + 2;
    step();
    flush_i = 1'b0;
    step();
    step();
    m_en = 1'b1; done_at = -1;
    repeat (3) step();
    req_valid_i = '0;
    repeat (4) step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid_i = 4'($urandom_range(0, 15));
      randomize_ops();
      step();
    end
    req_valid_i = '0;
    repeat (4) step();

    // Reset with three operations in flight.
    req_valid_i = 4'hF;
    for (int i = 0; i < 3; i++) begin randomize_ops(); step(); end
    #2 rst_ni = 1'b0;
    #1 chk_zero_outputs("midreset");
    exp_q.delete();
    m_ptr = 0;
    for (int r = 0; r < NREQ; r++) m_cnt[r] = 0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    req_valid_i = '0;
    repeat (4) step();
    for (int i = 0; i < 20; i++) begin
      req_valid_i = 4'($urandom_range(0, 15));
      randomize_ops();
      step();
    end
    req_valid_i = '0;
    repeat (4) step();

`ifdef PE_RR_SCHED_PERF_EN
    chk_cnt("pre_sat");
    // Requester 2 granted 70000 times without per-cycle checking.
    req_valid_i = 4'b0100; opa[2] = 32'd3; opb[2] = 32'd4;
    repeat (70000) @(posedge clk_i);
    #1 req_valid_i = '0;
    m_cnt[2] = (m_cnt[2] + 70000 > 65535) ? 65535 : m_cnt[2] + 70000;
    m_ptr = 3;
    repeat (PE_LAT + 1) @(posedge clk_i);
    #1;
    step();
    @(negedge clk_i);
    chk_cnt("sat");
    @(posedge clk_i); #1;
    flush_i = 1'b1; m_en = 1'b0; done_at = cyc + 2;
    step();
    flush_i = 1'b0;
    step();
    step();
    m_en = 1'b1; done_at = -1;
    @(negedge clk_i);
    chk_cnt("cleared");
    @(posedge clk_i); #1;
    req_valid_i = 4'b0110; randomize_ops();
    repeat (3) step();
    req_valid_i = '0;
    repeat (4) step();
    @(negedge clk_i);
    chk_cnt("resumed");
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
